// File: rtl/plcp_pkg.sv
// Shared types and constants for the 802.11a PLCP frame sequencer.
package plcp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StSignal,
      StService,
      StData,
      StTail
   } plcp_state_e;

   // RATE codes R1..R4 (MSB is R1)
   localparam logic [3:0] Rate6  = 4'b1101;
   localparam logic [3:0] Rate9  = 4'b1111;
   localparam logic [3:0] Rate12 = 4'b0101;
   localparam logic [3:0] Rate18 = 4'b0111;
   localparam logic [3:0] Rate24 = 4'b1001;
   localparam logic [3:0] Rate36 = 4'b1011;
   localparam logic [3:0] Rate48 = 4'b0001;
   localparam logic [3:0] Rate54 = 4'b0011;

   localparam int unsigned SigRateW  = 4;
   localparam int unsigned SigRsvdW  = 1;
   localparam int unsigned SigLenW   = 12;
   localparam int unsigned SigParW   = 1;
   localparam int unsigned SigTailW  = 6;
   localparam int unsigned SigTotalW = SigRateW + SigRsvdW + SigLenW + SigParW + SigTailW;

   // x^7 + x^4 + 1: feedback from state bits 6 and 3
   localparam logic [6:0] ScrTaps = 7'b100_1000;

   function automatic logic is_valid_rate(input logic [3:0] rate);
      logic ok;
      case (rate)
         Rate6, Rate9, Rate12, Rate18, Rate24, Rate36, Rate48, Rate54: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/plcp_scrambler.sv
// 7-bit frame-synchronous scrambler LFSR with seed load and advance enable.
module plcp_scrambler
   import plcp_pkg::*;
#(
   parameter logic [6:0] Seed = 7'h5D
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic bit_o
);

   logic [6:0] state_q, state_d;
   logic       fb;

   assign fb    = ^(state_q & ScrTaps);
   assign bit_o = fb;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = Seed;
      end else if (en_i) begin
         state_d = {state_q[5:0], fb};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= Seed;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/plcp_frame_tx.sv
// 802.11a PLCP frame sequencer: preamble, SIGNAL, scrambled SERVICE/PSDU, tail.
module plcp_frame_tx
   import plcp_pkg::*;
#(
   parameter int unsigned              PREAMBLE_BITS    = 96,
   parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = {12{8'hAA}},
   parameter logic [6:0]               SCRAMBLER_SEED   = 7'h5D,
   parameter int unsigned              LENGTH_WIDTH     = 12,
   parameter int unsigned              SERVICE_BITS     = 16,
   parameter int unsigned              TAIL_BITS        = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [3:0]              rate_i,
   input  logic [LENGTH_WIDTH-1:0] length_i,
   input  logic                    data_i,
   input  logic                    data_valid_i,
   output logic                    data_ready_o,
   output logic                    out_o,
   output logic                    out_valid_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o
);

   localparam int unsigned CntW  = (LENGTH_WIDTH + 3 > 8) ? LENGTH_WIDTH + 3 : 8;
   localparam int unsigned CopyW = (LENGTH_WIDTH < SigLenW) ? LENGTH_WIDTH : SigLenW;

   plcp_state_e             state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [3:0]              rate_q, rate_d;
   logic [LENGTH_WIDTH-1:0] len_q, len_d;
   logic                    out_q, out_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    scr_load, scr_en, scr_bit;
   logic                    data_ready;
   logic [SigLenW-1:0]      sig_len;
   logic [SigTotalW-1:0]    sig_field;
   logic [SigTotalW-1:0]    sig_sh;
   logic [PREAMBLE_BITS-1:0] pre_sh;
   logic [CntW-1:0]         data_total;

   plcp_scrambler #(
      .Seed (SCRAMBLER_SEED)
   ) u_scrambler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (scr_load),
      .en_i   (scr_en),
      .bit_o  (scr_bit)
   );

   // SIGNAL field with bit 0 being the first bit on the line (R1)
   always_comb begin
      sig_len = '0;
      for (int i = 0; i < CopyW; i++) begin
         sig_len[i] = len_q[i];
      end
      sig_field = {{SigTailW{1'b0}}, ^{rate_q, sig_len}, sig_len, 1'b0,
                   rate_q[0], rate_q[1], rate_q[2], rate_q[3]};
   end

   assign sig_sh     = sig_field >> cnt_q;
   assign pre_sh     = PREAMBLE_PATTERN << cnt_q;
   assign data_total = CntW'({len_q, 3'b000});

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rate_d      = rate_q;
      len_d       = len_q;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      busy_d      = (state_q != StIdle);
      scr_load    = 1'b0;
      scr_en      = 1'b0;
      data_ready  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (is_valid_rate(rate_i) && (length_i != '0)) begin
                  rate_d   = rate_i;
                  len_d    = length_i;
                  cnt_d    = '0;
                  scr_load = 1'b1;
                  state_d  = StPreamble;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         StPreamble: begin
            out_d       = pre_sh[PREAMBLE_BITS-1];
            out_valid_d = 1'b1;
            if (cnt_q == CntW'(PREAMBLE_BITS - 1)) begin
               cnt_d   = '0;
               state_d = StSignal;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSignal: begin
            out_d       = sig_sh[0];
            out_valid_d = 1'b1;
            if (cnt_q == CntW'(SigTotalW - 1)) begin
               cnt_d   = '0;
               state_d = StService;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StService: begin
            out_d       = scr_bit;
            out_valid_d = 1'b1;
            scr_en      = 1'b1;
            if (cnt_q == CntW'(SERVICE_BITS - 1)) begin
               cnt_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            data_ready = 1'b1;
            // A stall holds both the bit counter and the scrambler
            if (data_valid_i) begin
               out_d       = data_i ^ scr_bit;
               out_valid_d = 1'b1;
               scr_en      = 1'b1;
               if (cnt_q == data_total - CntW'(1)) begin
                  cnt_d   = '0;
                  state_d = StTail;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StTail: begin
            out_valid_d = 1'b1;
            scr_en      = 1'b1;
            if (cnt_q == CntW'(TAIL_BITS - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rate_q      <= '0;
         len_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rate_q      <= rate_d;
         len_q       <= len_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign data_ready_o = data_ready;
   assign out_o        = out_q;
   assign out_valid_o  = out_valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

endmodule

// File: tb/tb_plcp_frame_tx.sv
// Directed bench for plcp_frame_tx: Start vector table plus multi-cycle frame sequences.
module tb_plcp_frame_tx;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [3:0]  rate_i = 4'b0;
   logic [11:0] length_i = 12'd0;
   logic        data_i = 1'b0;
   logic        data_valid_i = 1'b0;

   logic data_ready_o, out_o, out_valid_o, busy_o, done_o, error_o;
   logic data_ready_b, out_b, out_valid_b, busy_b, done_b, error_b;

   always #5 clk = ~clk;

   plcp_frame_tx u_dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .rate_i       (rate_i),
      .length_i     (length_i),
      .data_i       (data_i),
      .data_valid_i (data_valid_i),
      .data_ready_o (data_ready_o),
      .out_o        (out_o),
      .out_valid_o  (out_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   // Same stimulus, all-ones seed, for the known scrambler sequence
   plcp_frame_tx #(
      .SCRAMBLER_SEED (7'h7F)
   ) u_dut_7f (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .rate_i       (rate_i),
      .length_i     (length_i),
      .data_i       (data_i),
      .data_valid_i (data_valid_i),
      .data_ready_o (data_ready_b),
      .out_o        (out_b),
      .out_valid_o  (out_valid_b),
      .busy_o       (busy_b),
      .done_o       (done_b),
      .error_o      (error_b)
   );

   typedef struct {
      logic [3:0]  rate;
      logic [11:0] len;
      bit          exp_err;
      logic [23:0] sig;  // MSB is the first SIGNAL bit on the line
   } vec_t;

   localparam int NVec = 12;
   localparam int FrameBits = 942;

   vec_t vecs[NVec];
   int   n_checks = 0;
   int   n_errors = 0;

   bit   got_a[2048];
   bit   got_b[2048];
   bit   exp_frame[2048];
   int   n_bits, n_done, done_idx, n_data_cyc, n_gaps, twin_diff;
   bit   saw_err, aborted;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int idle_outs();
      return int'({out_o, out_valid_o, busy_o, done_o, error_o, data_ready_o});
   endfunction

   function automatic bit pay_bit(input int idx);
      int  b;
      logic [7:0] v;
      b = idx / 8;
      v = (b == 0) ? 8'h00 : 8'((b * 37 + 5) & 255);
      return v[idx % 8];
   endfunction

   function automatic int frame_mism();
      int m;
      m = 0;
      for (int i = 0; i < FrameBits; i++) begin
         if (got_a[i] != exp_frame[i]) m++;
      end
      return m;
   endfunction

   task automatic build_expected();
      logic [6:0]  s;
      logic [23:0] sig;
      bit          sb;
      s   = 7'h5D;
      sig = 24'b1011_0_001001100000_0_000000;
      for (int i = 0; i < 96; i++) exp_frame[i] = (i % 2 == 0);
      for (int i = 0; i < 24; i++) exp_frame[96 + i] = sig[23 - i];
      for (int i = 0; i < 16; i++) begin
         sb = s[6] ^ s[3];
         exp_frame[120 + i] = sb;
         s = {s[5:0], sb};
      end
      for (int i = 0; i < 800; i++) begin
         sb = s[6] ^ s[3];
         exp_frame[136 + i] = pay_bit(i) ^ sb;
         s = {s[5:0], sb};
      end
      for (int i = 0; i < 6; i++) exp_frame[936 + i] = 1'b0;
   endtask

   task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input bit toggle,
                            input int abort_at, input int restart_at);
      int idx;
      bit acc, tog, started, finished;
      n_bits = 0; n_done = 0; done_idx = -1; n_data_cyc = 0; n_gaps = 0; twin_diff = 0;
      saw_err = 0; aborted = 0;
      idx = 0; acc = 0; tog = 0; started = 0; finished = 0;
      rate_i = rate; length_i = len; start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         step();
         if (acc) idx++;
         if (error_o) saw_err = 1;
         if (out_valid_o != out_valid_b || busy_o != busy_b || done_o != done_b ||
             data_ready_o != data_ready_b || error_o != error_b) twin_diff++;
         if (out_valid_o && n_bits < 2048) begin
            got_a[n_bits] = out_o;
            got_b[n_bits] = out_b;
            n_bits++;
         end
         if (done_o) begin
            n_done++;
            done_idx = out_valid_o ? n_bits : -1;
         end
         if (data_ready_o) n_data_cyc++;
         if (data_ready_o && !out_valid_o) n_gaps++;
         if (busy_o) started = 1;
         else if (started) begin
            finished = 1;
            break;
         end
         start_i = (cyc == restart_at);
         if (abort_at >= 0 && idx >= abort_at) begin
            data_valid_i = 1'b0;
            rst_i = 1'b1;
            step();
            rst_i = 1'b0;
            aborted = 1;
            finished = 1;
            break;
         end
         if (data_ready_o) begin
            if (toggle) begin
               data_valid_i = tog;
               tog = ~tog;
            end else begin
               data_valid_i = 1'b1;
            end
            data_i = (idx < 8 * int'(len)) ? pay_bit(idx) : 1'b0;
         end else begin
            data_valid_i = 1'b0;
            data_i = 1'b0;
         end
         acc = data_ready_o && data_valid_i;
      end
      start_i = 1'b0;
      data_valid_i = 1'b0;
      if (!finished) begin
         n_checks++;
         n_errors++;
         $display("FAIL frame_timeout: got no frame end expected end within 6000 cycles");
      end
   endtask

   initial begin
      int           m;
      logic [15:0]  svc7f;
      logic [7:0]   dat7f;
      bit           bits[120];

      vecs[0]  = '{4'b1101, 12'd1,     0, 24'b1101_0_100000000000_0_000000};
      vecs[1]  = '{4'b0101, 12'hFFF,   0, 24'b0101_0_111111111111_0_000000};
      vecs[2]  = '{4'b0001, 12'd3,     0, 24'b0001_0_110000000000_1_000000};
      vecs[3]  = '{4'b1111, 12'h800,   0, 24'b1111_0_000000000001_1_000000};
      vecs[4]  = '{4'b1011, 12'd100,   0, 24'b1011_0_001001100000_0_000000};
      vecs[5]  = '{4'b0111, 12'd2,     0, 24'b0111_0_010000000000_0_000000};
      vecs[6]  = '{4'b1001, 12'h555,   0, 24'b1001_0_101010101010_0_000000};
      vecs[7]  = '{4'b0011, 12'h00F,   0, 24'b0011_0_111100000000_0_000000};
      vecs[8]  = '{4'b0000, 12'd5,     1, 24'b0};
      vecs[9]  = '{4'b1101, 12'd0,     1, 24'b0};
      vecs[10] = '{4'b1000, 12'd5,     1, 24'b0};
      vecs[11] = '{4'b1110, 12'd5,     1, 24'b0};

      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      check("reset_outputs", idle_outs(), 0);
      step();
      check("idle_after_reset", idle_outs(), 0);

      for (int v = 0; v < NVec; v++) begin
         rate_i = vecs[v].rate;
         length_i = vecs[v].len;
         start_i = 1'b1;
         step();
         start_i = 1'b0;
         check($sformatf("v%0d_error_pulse", v), int'(error_o), int'(vecs[v].exp_err));
         step();
         check($sformatf("v%0d_error_clear", v), int'(error_o), 0);
         check($sformatf("v%0d_busy", v), int'(busy_o), int'(!vecs[v].exp_err));
         check($sformatf("v%0d_out_valid", v), int'(out_valid_o), int'(!vecs[v].exp_err));
         if (!vecs[v].exp_err) begin
            m = 0;
            for (int k = 0; k < 120; k++) begin
               if (k > 0) step();
               bits[k] = out_o;
               if (!out_valid_o) m++;
            end
            for (int k = 0; k < 24; k++) begin
               if (bits[96 + k] != vecs[v].sig[23 - k]) m++;
            end
            check($sformatf("v%0d_signal_mism", v), m, 0);
            check($sformatf("v%0d_preamble_bit0", v), int'(bits[0]), 1);
            rst_i = 1'b1;
            step();
            rst_i = 1'b0;
            check($sformatf("v%0d_reset_idle", v), idle_outs(), 0);
         end else begin
            step();
            check($sformatf("v%0d_stays_idle", v), idle_outs(), 0);
         end
      end

      build_expected();

      // Plain frame, no stalls
      step();
      run_frame(4'b1011, 12'd100, 0, -1, -1);
      check("f1_valid_bits", n_bits, FrameBits);
      check("f1_frame_mism", frame_mism(), 0);
      check("f1_done_count", n_done, 1);
      check("f1_done_on_last", done_idx, FrameBits);
      check("f1_data_cycles", n_data_cyc, 800);
      check("f1_gaps", n_gaps, 0);
      check("f1_no_error", int'(saw_err), 0);
      check("f1_twin_ctrl_diff", twin_diff, 0);
      svc7f = 16'b0000111011110010;
      dat7f = 8'b11001001;
      m = 0;
      for (int i = 0; i < 16; i++) if (got_b[120 + i] != svc7f[15 - i]) m++;
      check("seed7f_service_mism", m, 0);
      m = 0;
      for (int i = 0; i < 8; i++) if (got_b[136 + i] != dat7f[7 - i]) m++;
      check("seed7f_data_mism", m, 0);

      // DataValid alternating 0/1 through DATA
      step();
      run_frame(4'b1011, 12'd100, 1, -1, -1);
      check("f2_valid_bits", n_bits, FrameBits);
      check("f2_frame_mism", frame_mism(), 0);
      check("f2_data_cycles", n_data_cyc, 1600);
      check("f2_has_gaps", int'(n_gaps > 0), 1);
      check("f2_done_count", n_done, 1);
      check("f2_done_on_last", done_idx, FrameBits);

      // Reset in the middle of DATA, then a fresh frame
      step();
      run_frame(4'b1011, 12'd100, 0, 400, -1);
      check("f3_aborted", int'(aborted), 1);
      check("f3_reset_idle", idle_outs(), 0);
      step();
      check("f3_still_idle", idle_outs(), 0);
      run_frame(4'b1011, 12'd100, 0, -1, -1);
      check("f4_valid_bits", n_bits, FrameBits);
      check("f4_frame_mism", frame_mism(), 0);
      check("f4_done_count", n_done, 1);

      // Start pulsed during SIGNAL is ignored
      step();
      run_frame(4'b1011, 12'd100, 0, -1, 100);
      check("f5_valid_bits", n_bits, FrameBits);
      check("f5_frame_mism", frame_mism(), 0);
      check("f5_done_count", n_done, 1);
      check("f5_no_error", int'(saw_err), 0);
      step();
      step();
      check("f5_idle_after", idle_outs(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
